// File: rtl/ps2_defs.sv
`default_nettype none
// ============================================================================
//  Package     : ps2_defs
//  Description : Shared scan-code constants, ASCII codes, decoder FSM state
//                encoding and the lookup-table entry type for the PS/2
//                key decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_defs;

    // Set-2 prefix and modifier scan codes
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_TAB    = 8'h0D;
    localparam logic [7:0] SC_SPACE  = 8'h29;

    // Keyboard status / protocol bytes that never start a key sequence
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    // Control characters produced by the decoder
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_TAB = 8'h09;
    localparam logic [7:0] ASCII_SP  = 8'h20;

    // Scan-code sequence tracking states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_t;

    // One lookup-table row: letters use the shift^caps rule, everything
    // else selects alt purely on shift (alt==base for keys without a
    // shifted form).
    typedef struct packed {
        logic       hit;
        logic       letter;
        logic [7:0] base;
        logic [7:0] alt;
    } lut_entry_t;

    // Bytes that are dropped when seen outside a key sequence
    function automatic logic is_status_byte(input logic [7:0] code);
        return (code == SC_PAUSE) || (code == SC_BAT_OK) || (code == SC_ACK) ||
               (code == SC_ECHO)  || (code == SC_ERR0)   || (code == SC_ERR1);
    endfunction

endpackage : ps2_defs
`default_nettype wire

// File: rtl/ps2_ascii_lut.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_ascii_lut
//  Description : Combinational set-2 scan code to ASCII translation (US
//                layout) with Shift and CapsLock handling.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_ascii_lut
    import ps2_defs::*;
(
    input  logic       shift_i,
    input  logic       caps_i,
    input  logic [7:0] code_i,
    output logic       hit_o,
    output logic [7:0] ascii_o
);

    lut_entry_t w_e;
    logic       w_use_alt;

    // Table of every key that produces a character
    always_comb begin
        w_e = '{1'b0, 1'b0, 8'h00, 8'h00};
        case (code_i)
            // letters
            8'h1C: w_e = '{1'b1, 1'b1, 8'h61, 8'h41};
            8'h32: w_e = '{1'b1, 1'b1, 8'h62, 8'h42};
            8'h21: w_e = '{1'b1, 1'b1, 8'h63, 8'h43};
            8'h23: w_e = '{1'b1, 1'b1, 8'h64, 8'h44};
            8'h24: w_e = '{1'b1, 1'b1, 8'h65, 8'h45};
            8'h2B: w_e = '{1'b1, 1'b1, 8'h66, 8'h46};
            8'h34: w_e = '{1'b1, 1'b1, 8'h67, 8'h47};
            8'h33: w_e = '{1'b1, 1'b1, 8'h68, 8'h48};
            8'h43: w_e = '{1'b1, 1'b1, 8'h69, 8'h49};
            8'h3B: w_e = '{1'b1, 1'b1, 8'h6A, 8'h4A};
            8'h42: w_e = '{1'b1, 1'b1, 8'h6B, 8'h4B};
            8'h4B: w_e = '{1'b1, 1'b1, 8'h6C, 8'h4C};
            8'h3A: w_e = '{1'b1, 1'b1, 8'h6D, 8'h4D};
            8'h31: w_e = '{1'b1, 1'b1, 8'h6E, 8'h4E};
            8'h44: w_e = '{1'b1, 1'b1, 8'h6F, 8'h4F};
            8'h4D: w_e = '{1'b1, 1'b1, 8'h70, 8'h50};
            8'h15: w_e = '{1'b1, 1'b1, 8'h71, 8'h51};
            8'h2D: w_e = '{1'b1, 1'b1, 8'h72, 8'h52};
            8'h1B: w_e = '{1'b1, 1'b1, 8'h73, 8'h53};
            8'h2C: w_e = '{1'b1, 1'b1, 8'h74, 8'h54};
            8'h3C: w_e = '{1'b1, 1'b1, 8'h75, 8'h55};
            8'h2A: w_e = '{1'b1, 1'b1, 8'h76, 8'h56};
            8'h1D: w_e = '{1'b1, 1'b1, 8'h77, 8'h57};
            8'h22: w_e = '{1'b1, 1'b1, 8'h78, 8'h58};
            8'h35: w_e = '{1'b1, 1'b1, 8'h79, 8'h59};
            8'h1A: w_e = '{1'b1, 1'b1, 8'h7A, 8'h5A};
            // digit row
            8'h45: w_e = '{1'b1, 1'b0, 8'h30, 8'h29};
            8'h16: w_e = '{1'b1, 1'b0, 8'h31, 8'h21};
            8'h1E: w_e = '{1'b1, 1'b0, 8'h32, 8'h40};
            8'h26: w_e = '{1'b1, 1'b0, 8'h33, 8'h23};
            8'h25: w_e = '{1'b1, 1'b0, 8'h34, 8'h24};
            8'h2E: w_e = '{1'b1, 1'b0, 8'h35, 8'h25};
            8'h36: w_e = '{1'b1, 1'b0, 8'h36, 8'h5E};
            8'h3D: w_e = '{1'b1, 1'b0, 8'h37, 8'h26};
            8'h3E: w_e = '{1'b1, 1'b0, 8'h38, 8'h2A};
            8'h46: w_e = '{1'b1, 1'b0, 8'h39, 8'h28};
            // punctuation
            8'h0E: w_e = '{1'b1, 1'b0, 8'h60, 8'h7E};
            8'h4E: w_e = '{1'b1, 1'b0, 8'h2D, 8'h5F};
            8'h55: w_e = '{1'b1, 1'b0, 8'h3D, 8'h2B};
            8'h54: w_e = '{1'b1, 1'b0, 8'h5B, 8'h7B};
            8'h5B: w_e = '{1'b1, 1'b0, 8'h5D, 8'h7D};
            8'h5D: w_e = '{1'b1, 1'b0, 8'h5C, 8'h7C};
            8'h4C: w_e = '{1'b1, 1'b0, 8'h3B, 8'h3A};
            8'h52: w_e = '{1'b1, 1'b0, 8'h27, 8'h22};
            8'h41: w_e = '{1'b1, 1'b0, 8'h2C, 8'h3C};
            8'h49: w_e = '{1'b1, 1'b0, 8'h2E, 8'h3E};
            8'h4A: w_e = '{1'b1, 1'b0, 8'h2F, 8'h3F};
            // whitespace / editing keys: unaffected by modifiers
            SC_SPACE: w_e = '{1'b1, 1'b0, ASCII_SP,  ASCII_SP};
            SC_ENTER: w_e = '{1'b1, 1'b0, ASCII_CR,  ASCII_CR};
            SC_BKSP:  w_e = '{1'b1, 1'b0, ASCII_BS,  ASCII_BS};
            SC_TAB:   w_e = '{1'b1, 1'b0, ASCII_TAB, ASCII_TAB};
            default:  w_e = '{1'b0, 1'b0, 8'h00, 8'h00};
        endcase
    end

    // CapsLock only inverts the case of letters
    assign w_use_alt = w_e.letter ? (shift_i ^ caps_i) : shift_i;
    assign hit_o     = w_e.hit;
    assign ascii_o   = w_use_alt ? w_e.alt : w_e.base;

endmodule : ps2_ascii_lut
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_decoder
//  Description : Turns set-2 scan-code bytes into ASCII characters, tracking
//                break/extended prefixes, Shift and CapsLock, and queues the
//                characters in an output FIFO with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder
    import ps2_defs::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [7:0] ascii_out,
    output logic       ascii_valid,
    input  logic       ascii_ready,
    output logic       overflow,
    output logic       caps_on
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // ------------------------------------------------------------------
    // Decoder state
    // ------------------------------------------------------------------
    kbd_state_t state_q, state_d;
    logic       shift_l_q, shift_l_d;
    logic       shift_r_q, shift_r_d;
    logic       caps_on_q, caps_on_d;
    logic       caps_held_q, caps_held_d;
    logic       push_q, push_d;
    logic [7:0] push_char_q, push_char_d;

    logic       w_lut_hit;
    logic [7:0] w_lut_ascii;

    ps2_ascii_lut u_lut (
        .shift_i (shift_l_q | shift_r_q),
        .caps_i  (caps_on_q),
        .code_i  (scan_code),
        .hit_o   (w_lut_hit),
        .ascii_o (w_lut_ascii)
    );

    // Decoder state and modifier registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_l_q   <= 1'b0;
            shift_r_q   <= 1'b0;
            caps_on_q   <= 1'b0;
            caps_held_q <= 1'b0;
            push_q      <= 1'b0;
            push_char_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            caps_on_q   <= caps_on_d;
            caps_held_q <= caps_held_d;
            push_q      <= push_d;
            push_char_q <= push_char_d;
        end
    end

    // Next-state: prefix tracking plus make/break actions on each strobe
    always_comb begin
        state_d     = state_q;
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        caps_on_d   = caps_on_q;
        caps_held_d = caps_held_q;
        push_d      = 1'b0;
        push_char_d = push_char_q;
        if (scan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_code == SC_BREAK) begin
                        state_d = ST_BRK;
                    end else if (scan_code == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (!is_status_byte(scan_code)) begin
                        case (scan_code)
                            SC_LSHIFT: shift_l_d = 1'b1;
                            SC_RSHIFT: shift_r_d = 1'b1;
                            SC_CAPS: begin
                                // typematic repeats of CapsLock must not re-toggle
                                if (!caps_held_q) begin
                                    caps_on_d   = ~caps_on_q;
                                    caps_held_d = 1'b1;
                                end
                            end
                            default: begin
                                if (w_lut_hit) begin
                                    push_d      = 1'b1;
                                    push_char_d = w_lut_ascii;
                                end
                            end
                        endcase
                    end
                end
                ST_EXT: begin
                    // extended keys produce no characters
                    state_d = (scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_BRK: begin
                    case (scan_code)
                        SC_LSHIFT: shift_l_d   = 1'b0;
                        SC_RSHIFT: shift_r_d   = 1'b0;
                        SC_CAPS:   caps_held_d = 1'b0;
                        default:   ;
                    endcase
                    state_d = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO: pointers carry one extra wrap bit
    // ------------------------------------------------------------------
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr_en;

    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_pop   = !w_empty && ascii_ready;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_wr_en = push_q && (!w_full || w_pop);

    // Pointer and sticky-overflow next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (w_wr_en) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (push_q && w_full && !w_pop) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO pointers and overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Character storage; contents are don't-care outside the valid window
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_char_q;
        end
    end

    assign ascii_valid = !w_empty;
    assign ascii_out   = w_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign overflow    = overflow_q;
    assign caps_on     = caps_on_q;

endmodule : ps2_key_decoder
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_decoder
//  Description : Self-checking bench for ps2_key_decoder with a character
//                scoreboard fed at stimulus time and drained on handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

    logic       clk;
    logic       reset;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic [7:0] ascii_out;
    logic       ascii_valid;
    logic       ascii_ready;
    logic       overflow;
    logic       caps_on;

    int         checks;
    int         failures;
    int         npop;
    logic [7:0] sb_q[$];

    ps2_key_decoder #(.FIFO_DEPTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .ascii_out   (ascii_out),
        .ascii_valid (ascii_valid),
        .ascii_ready (ascii_ready),
        .overflow    (overflow),
        .caps_on     (caps_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted character is compared with the oldest expectation
    always @(negedge clk) begin
        if (!reset && ascii_valid && ascii_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_char", {24'd0, ascii_out}, 32'h0);
            end else begin
                check("char", {24'd0, ascii_out}, {24'd0, sb_q.pop_front()});
                npop++;
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        scan_code  = b;
        scan_valid = 1'b1;
        tick(1);
        scan_valid = 1'b0;
    endtask

    task automatic key(input logic [7:0] b, input logic [7:0] exp);
        sb_q.push_back(exp);
        send(b);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        sb_q.delete();
        reset = 1'b0;
        tick(1);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (sb_q.size() == 0 && !ascii_valid) done = 1'b1;
            else tick(1);
        end
        check("drain_left", sb_q.size(), 0);
        tick(4);
    endtask

    initial begin
        logic [7:0] codes [9];
        checks      = 0;
        failures    = 0;
        npop        = 0;
        reset       = 1'b1;
        scan_code   = 8'h00;
        scan_valid  = 1'b0;
        ascii_ready = 1'b0;
        codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
        tick(3);
        reset = 1'b0;
        tick(1);

        // reset state
        check("rst_valid", ascii_valid, 0);
        check("rst_out", ascii_out, 0);
        check("rst_ovf", overflow, 0);
        check("rst_caps", caps_on, 0);

        // single make then break, with latency check
        ascii_ready = 1'b1;
        key(8'h1C, 8'h61);
        check("lat_1cyc", ascii_valid, 0);
        tick(1);
        check("lat_2cyc", ascii_valid, 1);
        send(8'hF0); send(8'h1C);
        wait_drain();

        // left and right shift
        send(8'h12); key(8'h1C, 8'h41); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        key(8'h1C, 8'h61);
        send(8'h59); key(8'h1C, 8'h41); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h59);
        key(8'h1C, 8'h61);
        wait_drain();

        // CapsLock with typematic repeat, shift interaction, digits ignore caps
        send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
        check("caps_once", caps_on, 1);
        key(8'h1C, 8'h41);
        key(8'h16, 8'h31);
        send(8'h12); key(8'h1C, 8'h61); key(8'h16, 8'h21); send(8'hF0); send(8'h12);
        send(8'h58); send(8'hF0); send(8'h58);
        check("caps_off", caps_on, 0);
        wait_drain();

        // extended keys, status bytes and control characters
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h12);
        send(8'hAA); send(8'hFA); send(8'h42 ^ 8'h42);
        key(8'h5A, 8'h0D);
        key(8'h29, 8'h20);
        key(8'h66, 8'h08);
        key(8'h0D, 8'h09);
        wait_drain();

        // overflow: 9 pushes into an 8-deep FIFO with the consumer stalled
        ascii_ready = 1'b0;
        for (int i = 0; i < 8; i++) key(codes[i], 8'h61 + 8'(i));
        tick(2);
        check("full_no_ovf", overflow, 0);
        send(codes[8]);
        tick(2);
        check("ovf_set", overflow, 1);
        check("ovf_head", ascii_out, 8'h61);
        tick(3);
        check("ovf_head_stable", ascii_out, 8'h61);
        ascii_ready = 1'b1;
        wait_drain();
        check("ovf_sticky", overflow, 1);

        // full FIFO with simultaneous push and pop
        do_reset();
        check("rst2_ovf", overflow, 0);
        ascii_ready = 1'b0;
        for (int i = 0; i < 8; i++) key(codes[i], 8'h61 + 8'(i));
        tick(2);
        key(8'h1A, 8'h7A);
        ascii_ready = 1'b1;
        tick(1);
        ascii_ready = 1'b0;
        tick(2);
        check("pushpop_ovf", overflow, 0);
        npop = 0;
        ascii_ready = 1'b1;
        wait_drain();
        check("pushpop_remaining", npop, 8);

        // reset in the middle of an E0 sequence clears everything
        ascii_ready = 1'b0;
        send(8'h58); send(8'hF0); send(8'h58); send(8'h12);
        key(8'h1C, 8'h61); key(8'h32, 8'h62);
        tick(2);
        check("pre_rst_caps", caps_on, 1);
        send(8'hE0);
        reset = 1'b1;
        send(8'h1C);
        tick(1);
        sb_q.delete();
        reset = 1'b0;
        tick(1);
        check("midrst_valid", ascii_valid, 0);
        check("midrst_caps", caps_on, 0);
        ascii_ready = 1'b1;
        key(8'h1C, 8'h61);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_ps2_key_decoder
`default_nettype wire
